// File: rtl/pwm_multi.sv
// pwm_multi -- N-channel PWM generator driven by one shared period counter.
//
// The counter runs in up, down or up-down (center-aligned) mode. Period,
// compare values and mode are taken from shadow inputs. The shadows are
// copied into active registers only at a period boundary, or continuously
// while counting is disabled, so waveforms never glitch mid-period.
// Polarity is not shadowed and takes effect on the next edge.
//
// Parameters
//   W      counter / period / compare width (W >= 2)
//   N      number of PWM channels (N >= 1)
// Ports
//   clk50m in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   en     in   count enable; the counter holds while low
//   mode   in   shadow mode: 00 up, 01 down, 10 up-down, 11 same as 00
//   per    in   shadow period
//   cmp    in   shadow compare values, channel i at [i*W +: W]
//   pol    in   per-channel output inversion
//   cnt    out  current counter value
//   dir    out  count direction, 0 = up, 1 = down
//   prd    out  one-cycle pulse on the first count of each period
//   pwm    out  registered PWM outputs
module pwm_multi #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic             clk50m,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [W-1:0]     per,
   input  logic [N*W-1:0]   cmp,
   input  logic [N-1:0]     pol,
   output logic [W-1:0]     cnt,
   output logic             dir,
   output logic             prd,
   output logic [N-1:0]     pwm
);

   localparam logic [1:0]   M_UP = 2'b00;
   localparam logic [1:0]   M_DN = 2'b01;
   localparam logic [1:0]   M_UD = 2'b10;
   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] TWO  = W'(2);

   // Encoding 11 behaves exactly like up counting.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'b11) ? M_UP : m;
   endfunction

   logic [W-1:0] per_a;
   logic [W-1:0] cmp_a [N];
   logic [1:0]   mode_a;

   logic [1:0]   mode_old;
   logic [1:0]   mode_new;
   logic [W-1:0] per_m1;
   logic [W-1:0] per_m2;
   logic         degen;
   logic         degen_new;
   logic         boundary;
   logic         load;
   logic [W-1:0] cnt_nxt;
   logic         dir_nxt;

   assign mode_old  = norm_mode(mode_a);
   assign mode_new  = norm_mode(mode);
   assign per_m1    = per_a - ONE;
   assign per_m2    = per_a - TWO;
   assign degen     = (per_a < TWO);
   assign degen_new = (per < TWO);
   assign load      = boundary | ~en;

   // Stage 0: boundary detection and next counter state
   always_comb begin
      boundary = 1'b0;
      if (en) begin
         if (degen) begin
            boundary = 1'b1;
         end else begin
            case (mode_old)
               M_DN:    boundary = (cnt == '0);
               M_UD:    boundary = (cnt == '0) && dir;
               // >= rather than == so an out-of-range count still wraps
               default: boundary = (cnt >= per_m1);
            endcase
         end
      end

      cnt_nxt = cnt;
      dir_nxt = dir;
      if (boundary) begin
         // Start value of the next period comes from the values being loaded.
         if (degen_new) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
         end else begin
            case (mode_new)
               M_DN: begin
                  cnt_nxt = per - ONE;
                  dir_nxt = 1'b1;
               end
               M_UD: begin
                  // Staying in up-down: 0 was the last down count, so carry on to 1.
                  cnt_nxt = (mode_old == M_UD) ? ONE : '0;
                  dir_nxt = 1'b0;
               end
               default: begin
                  cnt_nxt = '0;
                  dir_nxt = 1'b0;
               end
            endcase
         end
      end else if (en) begin
         case (mode_old)
            M_DN: begin
               cnt_nxt = cnt - ONE;
               dir_nxt = 1'b1;
            end
            M_UD: begin
               if (!dir) begin
                  // Turn around at the top without repeating per_a-1.
                  if (cnt >= per_m1) begin
                     cnt_nxt = per_m2;
                     dir_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + ONE;
                  end
               end else begin
                  cnt_nxt = cnt - ONE;
               end
            end
            default: begin
               cnt_nxt = cnt + ONE;
               dir_nxt = 1'b0;
            end
         endcase
      end
   end

   // Stage 1: counter, active registers and PWM outputs
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         dir    <= 1'b0;
         prd    <= 1'b0;
         pwm    <= '0;
         per_a  <= '0;
         mode_a <= M_UP;
         for (int i = 0; i < N; i++) cmp_a[i] <= '0;
      end else begin
         cnt <= cnt_nxt;
         dir <= dir_nxt;
         prd <= boundary;
         if (load) begin
            per_a  <= per;
            mode_a <= mode;
            for (int i = 0; i < N; i++) cmp_a[i] <= cmp[i*W +: W];
         end
         // Compare against the count currently shown, so pwm trails cnt by one cycle.
         for (int i = 0; i < N; i++) pwm[i] <= (cnt < cmp_a[i]) ^ pol[i];
      end
   end

endmodule
